add12u_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational 12-bit approximate adder (add12u family, 13-bit result) between NREQ requesters.
- Selects one pending request per cycle, drives the adder operands, registers the adder result together with the requester ID, and presents it on a single valid/ready response port.
- Sits between accelerator lanes and the single shared approximate adder instance, which lives outside this block.

---
 rtl/add12u_share_arb.sv | 131 +++++++++++++
 tb/tb_add12u_share_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/add12u_share_arb.sv
// Round-robin arbiter that time-shares one external approximate adder among NREQ lanes.
// Optional error statistics (exact vs. approximate sum) are enabled by ADD12U_ARB_ERRSTAT_EN.
module add12u_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       op_cnt
`ifdef ADD12U_ARB_ERRSTAT_EN
  ,
  output logic [W:0]        rsp_err,
  output logic [15:0]       err_cnt,
  output logic [W:0]        err_max
`endif
);

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_e;

  slot_e          state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [W:0]     sum_q;
  logic [IDW-1:0] id_q;
  logic [15:0]    cnt_q;
  logic [15:0]    cnt_d;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] sel_idx;
  logic           grant_vld;
  logic           can_accept;

  assign rsp_valid  = (state_q == S_FULL);
  assign can_accept = (state_q == S_EMPTY) | rsp_ready;
  assign rsp_sum    = sum_q;
  assign rsp_id     = id_q;
  assign op_cnt     = cnt_q;

  // Rotating priority scan: walking offsets downwards leaves the first hit from ptr_q in grant_idx.
  always_comb begin : arb
    int j;
    grant_idx = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr_q) + i) % NREQ;
      grant_idx = req_valid[j] ? IDW'(j) : grant_idx;
    end
    grant_vld = !rst && can_accept && (|req_valid);
    sel_idx   = grant_vld ? grant_idx : ptr_q;
    ptr_d     = (int'(grant_idx) == NREQ - 1) ? IDW'(0) : (grant_idx + IDW'(1));
    cnt_d     = cnt_q + 16'd1;
    req_ready = grant_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : {NREQ{1'b0}};
  end

  assign add_a = req_a[sel_idx*W +: W];
  assign add_b = req_b[sel_idx*W +: W];

  // Output slot FSM plus response capture, pointer and op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= IDW'(0);
      sum_q   <= {(W+1){1'b0}};
      id_q    <= IDW'(0);
      cnt_q   <= 16'd0;
    end else begin
      case (state_q)
        S_EMPTY: state_q <= grant_vld ? S_FULL : S_EMPTY;
        S_FULL:  state_q <= (grant_vld || !rsp_ready) ? S_FULL : S_EMPTY;
        default: state_q <= S_EMPTY;
      endcase
      if (grant_vld) begin
        sum_q <= add_o;
        id_q  <= grant_idx;
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
      end else begin
        sum_q <= sum_q;
        id_q  <= id_q;
        ptr_q <= ptr_q;
        cnt_q <= cnt_q;
      end
    end
  end

`ifdef ADD12U_ARB_ERRSTAT_EN
  function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  logic [W:0]  exact_s;
  logic [W:0]  err_now;
  logic [W:0]  err_q;
  logic [15:0] ecnt_q;
  logic [W:0]  emax_q;

  assign exact_s = {1'b0, add_a} + {1'b0, add_b};
  assign err_now = abs_diff(exact_s, add_o);
  assign rsp_err = err_q;
  assign err_cnt = ecnt_q;
  assign err_max = emax_q;

  // Error statistics track only accepted ops; the counter saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= {(W+1){1'b0}};
      ecnt_q <= 16'd0;
      emax_q <= {(W+1){1'b0}};
    end else if (grant_vld) begin
      err_q  <= err_now;
      ecnt_q <= ((err_now != {(W+1){1'b0}}) && (ecnt_q != 16'hFFFF)) ? (ecnt_q + 16'd1) : ecnt_q;
      emax_q <= (err_now > emax_q) ? err_now : emax_q;
    end else begin
      err_q  <= err_q;
      ecnt_q <= ecnt_q;
      emax_q <= emax_q;
    end
  end
`endif

endmodule

// File: tb/tb_add12u_share_arb.sv
// Directed + randomized bench for add12u_share_arb against a cycle-level behavioural model.
module tb_add12u_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W:0]        add_o;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       op_cnt;
`ifdef ADD12U_ARB_ERRSTAT_EN
  logic [W:0]        rsp_err;
  logic [15:0]       err_cnt;
  logic [W:0]        err_max;
`endif

  int   checks = 0;
  int   errors = 0;
  logic inj = 1'b0;

  // Requester-side state and the reference model of the response slot.
  bit         rv[NREQ];
  logic [11:0] ra[NREQ];
  logic [11:0] rb[NREQ];
  bit         hold_all = 1'b0;
  bit         m_valid;
  int         m_sum, m_id, m_ptr, m_cnt, m_err, m_ecnt, m_emax;

  add12u_share_arb #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .op_cnt(op_cnt)
`ifdef ADD12U_ARB_ERRSTAT_EN
    , .rsp_err(rsp_err), .err_cnt(err_cnt), .err_max(err_max)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the external adder: exact, or exact-512 when inj is set.
  assign add_o = {1'b0, add_a} + {1'b0, add_b} - (inj ? 13'd512 : 13'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    m_err = 0; m_ecnt = 0; m_emax = 0;
  endtask

  task automatic step();
    int eg, sel, k, ex, ap, er;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = rv[i];
      req_a[i*W +: W]    = ra[i];
      req_b[i*W +: W]    = rb[i];
    end
    @(negedge clk);
    eg = -1;
    if (!rst && (!m_valid || rsp_ready)) begin
      for (int off = 0; off < NREQ; off++) begin
        k = (m_ptr + off) % NREQ;
        if (eg < 0 && rv[k]) eg = k;
      end
    end
    chk("req_ready", 32'(req_ready), (eg < 0) ? 0 : (1 << eg));
    sel = (eg < 0) ? m_ptr : eg;
    chk("add_a", 32'(add_a), 32'(ra[sel]));
    chk("add_b", 32'(add_b), 32'(rb[sel]));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_sum", 32'(rsp_sum), m_sum);
    chk("rsp_id", 32'(rsp_id), m_id);
    chk("op_cnt", 32'(op_cnt), m_cnt);
`ifdef ADD12U_ARB_ERRSTAT_EN
    chk("rsp_err", 32'(rsp_err), m_err);
    chk("err_cnt", 32'(err_cnt), m_ecnt);
    chk("err_max", 32'(err_max), m_emax);
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (eg >= 0) begin
      ex = int'(ra[eg]) + int'(rb[eg]);
      ap = (ex - (inj ? 512 : 0)) & 'h1FFF;
      er = (ex > ap) ? ex - ap : ap - ex;
      m_valid = 1'b1;
      m_sum   = ap;
      m_id    = eg;
      m_ptr   = (eg + 1) % NREQ;
      m_cnt   = (m_cnt + 1) & 'hFFFF;
      m_err   = er;
      if (er != 0 && m_ecnt < 65535) m_ecnt++;
      if (er > m_emax) m_emax = er;
      if (!hold_all) rv[eg] = 1'b0;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0; ra[i] = 12'(i); rb[i] = 12'(i);
    end
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    clear_reqs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("reset_valid", 32'(rsp_valid), 0);
    chk("reset_cnt", 32'(op_cnt), 0);
    rst = 1'b0;

    // Single request with exact adder.
    rv[0] = 1'b1; ra[0] = 12'd100; rb[0] = 12'd200; rsp_ready = 1'b1;
    step();
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_sum", 32'(rsp_sum), 300);
    chk("single_id", 32'(rsp_id), 0);
    chk("single_cnt", 32'(op_cnt), 1);
    step();

    // Fairness from a fresh pointer.
    rst = 1'b1; step(); rst = 1'b0;
    hold_all = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b1; ra[i] = 12'($urandom); rb[i] = 12'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_id", 32'(rsp_id), i % NREQ);
    end
    chk("fair_cnt", 32'(op_cnt), 8);
    hold_all = 1'b0;
    clear_reqs();
    step();

    // Backpressure holds the slot; the next grant continues round-robin.
    rv[1] = 1'b1; ra[1] = 12'd11; rb[1] = 12'd22;
    rv[3] = 1'b1; ra[3] = 12'd33; rb[3] = 12'd44;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    chk("bp_id", 32'(rsp_id), 1);
    chk("bp_sum", 32'(rsp_sum), 33);
    rsp_ready = 1'b1;
    step();
    chk("bp_next_id", 32'(rsp_id), 3);

    // Carry into the 13th bit.
    rv[2] = 1'b1; ra[2] = 12'hFFF; rb[2] = 12'h001;
    step();
    chk("carry_sum", 32'(rsp_sum), 32'h1000);
    chk("carry_id", 32'(rsp_id), 2);

    // Reset while a response is pending.
    rsp_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_cnt", 32'(op_cnt), 0);
    rsp_ready = 1'b1;
    rv[1] = 1'b1; rv[3] = 1'b1;
    step();
    chk("rst_first_id", 32'(rsp_id), 1);
    step();
    step();

    // Approximate result with a 512 error, then an exact op.
    inj = 1'b1; rv[0] = 1'b1; ra[0] = 12'd1000; rb[0] = 12'd1000;
    step();
    chk("approx_sum", 32'(rsp_sum), 1488);
`ifdef ADD12U_ARB_ERRSTAT_EN
    chk("approx_err", 32'(rsp_err), 512);
    chk("approx_ecnt", 32'(err_cnt), 1);
    chk("approx_emax", 32'(err_max), 512);
`endif
    inj = 1'b0; rv[0] = 1'b1; ra[0] = 12'd5; rb[0] = 12'd6;
    step();
`ifdef ADD12U_ARB_ERRSTAT_EN
    chk("exact_ecnt", 32'(err_cnt), 1);
`endif
    chk("exact_sum", 32'(rsp_sum), 11);

    // Randomized traffic with backpressure, error injection and occasional reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1; ra[i] = 12'($urandom); rb[i] = 12'($urandom);
        end
      end
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      inj       = 1'($urandom_range(0, 3) == 0);
      rst       = 1'($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0; rsp_ready = 1'b1; clear_reqs();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
